// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding constants and types.
// The control-unit decoder imports this same package.
package instr_encoder_pkg;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      NOR  = 4'd4,
      SLT  = 4'd5,
      JR   = 4'd6,
      LW   = 4'd7,
      SW   = 4'd8,
      BEQ  = 4'd9,
      ADDI = 4'd10,
      J    = 4'd11,
      JAL  = 4'd12
   } mnem_e;

   typedef logic [31:0] instr_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   function automatic instr_t r_type(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS field packer: mnemonic plus operand fields in,
// 32-bit instruction word and legality flag out.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [3:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output instr_t      word,
   output logic        legal
);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (mnem)
         ADD:     word = r_type(rs, rt, rd, FN_ADD);
         SUB:     word = r_type(rs, rt, rd, FN_SUB);
         AND:     word = r_type(rs, rt, rd, FN_AND);
         OR:      word = r_type(rs, rt, rd, FN_OR);
         NOR:     word = r_type(rs, rt, rd, FN_NOR);
         SLT:     word = r_type(rs, rt, rd, FN_SLT);
         // JR only carries rs; rt and rd are forced to zero
         JR:      word = r_type(rs, 5'd0, 5'd0, FN_JR);
         LW:      word = {OP_LW,   rs, rt, imm};
         SW:      word = {OP_SW,   rs, rt, imm};
         BEQ:     word = {OP_BEQ,  rs, rt, imm};
         ADDI:    word = {OP_ADDI, rs, rt, imm};
         J:       word = {OP_J,   target};
         JAL:     word = {OP_JAL, target};
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts mnemonic commands and writes encoded MIPS words
// into consecutive instruction-memory addresses, one word per two clocks.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        mnem,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   input  logic              clear,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;

   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

   state_e            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   instr_t            wdata_reg, wdata_next;
   logic              err_reg, err_next;

   instr_t            word;
   logic              legal;

   instr_pack u_pack (
      .mnem   (mnem),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .imm    (imm),
      .target (target),
      .word   (word),
      .legal  (legal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         count_reg <= '0;
         wdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         count_reg <= count_next;
         wdata_reg <= wdata_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      count_next = count_reg;
      wdata_next = wdata_reg;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (clear) begin
               addr_next  = '0;
               count_next = '0;
            end else if (in_valid) begin
               if (legal) begin
                  wdata_next = word;
                  state_next = WRITE;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         WRITE: begin
            // The strobe is already out this cycle; a clear only replaces the increment.
            if (clear) begin
               addr_next  = '0;
               count_next = '0;
               state_next = IDLE;
            end else begin
               addr_next  = addr_reg + 1'b1;
               count_next = count_reg + 1'b1;
               state_next = (count_reg == LAST) ? FULL : IDLE;
            end
         end
         FULL: begin
            if (clear) begin
               addr_next  = '0;
               count_next = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Decoded straight from state so that rst drops mem_we without waiting for a clock.
   assign in_ready  = (state_reg == IDLE);
   assign mem_we    = (state_reg == WRITE);
   assign full      = (state_reg == FULL);
   assign mem_addr  = addr_reg;
   assign count     = count_reg;
   assign mem_wdata = wdata_reg;
   assign err       = err_reg;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-002 Parameter ADDR_W: default 6; width of the instruction-memory word address (depth 2**ADDR_W).
REQ-003 Ports SHALL be:
- in_valid input 1: command present.
- in_ready output 1: encoder can accept a command.
- mnem input 4: mnemonic code from the package enum.
- rs, rt, rd input 5 each: register fields.
- imm input 16: immediate for I-type.
- target input 26: jump target for J-type.
- clear input 1: synchronous restart of the write address.
- mem_we output 1: instruction-memory write strobe.
- mem_addr output ADDR_W: word address.
- mem_wdata output 32: encoded instruction word.
- count output ADDR_W+1: number of words written.
- full output 1: memory full.
- err output 1: one-cycle pulse on an illegal mnemonic.

Function
REQ-004 Encoding SHALL be standard MIPS; the field encoder is combinational.
- R-type ADD/SUB/AND/OR/NOR/SLT: {000000, rs, rt, rd, 00000, funct}, with funct 100000/100010/100100/100101/100111/101010.
- JR: {000000, rs, 00000, 00000, 00000, 001000}.
- I-type LW 100011, SW 101011, BEQ 000100, ADDI 001000: {op, rs, rt, imm}.
- J-type J 000010, JAL 000011: {op, target}.
REQ-005 Mnemonic codes 13-15 SHALL be illegal.
- Accepting one SHALL pulse err for exactly one cycle.
- It SHALL produce no write and SHALL NOT change the address.
REQ-006 FSM states SHALL be IDLE, WRITE and FULL.
REQ-007 IDLE: in_ready=1.
- On in_valid with a legal mnem, the encoded word SHALL be registered into mem_wdata and the FSM SHALL go to WRITE.
REQ-008 WRITE: mem_we=1 for exactly one cycle with the current mem_addr, and in_ready=0.
- The next cycle, mem_addr and count SHALL increment.
- The FSM SHALL then go to IDLE, or to FULL if count reaches 2**ADDR_W.
REQ-009 Latency from accept to the mem_we cycle SHALL be 1 clock; throughput SHALL be one word per 2 clocks.
REQ-010 FULL: full=1, in_ready=0 and mem_we=0; mem_addr SHALL stay at its wrapped value 0.
REQ-011 clear SHALL set mem_addr=0, count=0 and state=IDLE on the next edge.
- clear has priority over an accept in the same cycle.
- If asserted during WRITE, the pending write SHALL still complete first, then the clear SHALL apply.
REQ-012 mem_wdata SHALL hold its value outside WRITE; it changes only on accept.

Reset
REQ-013 On rst, state=IDLE, mem_addr=0, count=0, mem_wdata=0, mem_we=0, err=0 and full=0.
- in_ready SHALL read 1 after release.
REQ-014 rst asserted during WRITE SHALL abort the write immediately; mem_we SHALL drop asynchronously.

Structure
REQ-015 A shared package SHALL hold:
- the mnemonic enum (ADD=0, SUB, AND, OR, NOR, SLT, JR, LW, SW, BEQ, ADDI, J, JAL=12);
- the 6-bit opcode and funct constants;
- the 32-bit instruction-word type.
These constants SHALL be the same ones used by the control-unit decoder.
REQ-016 Field packing SHALL be one combinational sub-module, instr_pack (mnem and fields in; word and legal flag out).

Verification
REQ-017 ADD rs=1 rt=2 rd=3 -> mem_we at addr 0 with wdata 0x00221820 one cycle after accept; count=1.
REQ-018 LW rs=29 rt=8 imm=4 -> 0x8FA80004; JR rs=31 -> 0x03E00008; J target=0x10 -> 0x08000010; JAL target=3 -> 0x0C000003.
REQ-019 mnem=14 -> err pulse of 1 cycle, no mem_we, count unchanged.
REQ-020 in_valid held high for 64 legal commands (ADDR_W=6):
- addresses 0..63 written in order;
- full=1 and in_ready=0 after the 64th write;
- further in_valid ignored.
REQ-021 clear while FULL -> state IDLE, count=0; the next write lands at addr 0.
REQ-022 rst asserted in the WRITE cycle -> mem_we low at once, all outputs at reset values, in_ready=1 after release.
